motor_cmd_ramp: RTL and testbench

Switch-to-motor command stage for the Basys 3 L298 drive. Synchronises and debounces the eight speed/direction switches, priority-decodes them into a target duty (0–10 of a 10-cycle PWM frame) and direction, and slews the duty one step at a time. On a direction reversal it ramps to zero, coasts through a dead time, and only then flips direction. Its outputs feed the PWM/direction output stage directly.

---
 rtl/motor_cmd_ramp.sv | 221 ++++++++++++++++++++++
 tb/tb_motor_cmd_ramp.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_ramp.sv
`default_nettype none
// ============================================================================
// Module   : motor_cmd_ramp
// Brief    : Switch sync/debounce, priority decode to duty/direction, and
//            duty slewing with ramp-down plus dead time on reversal.
//            Macro MOTOR_CMD_RAMP_EN enables one-step-per-tick duty slewing.
// Revision : 1.0  initial release
// ============================================================================
module motor_cmd_ramp #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RAMP_CYCLES     = 2_500_000,
    parameter int DEAD_CYCLES     = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    output logic [3:0] duty,
    output logic       dir_fwd,
    output logic       coast,
    output logic       busy
);

    localparam int c_DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_DEAD_W = $clog2(DEAD_CYCLES + 1);

    localparam logic [1:0] c_ST_RUN       = 2'd0;
    localparam logic [1:0] c_ST_RAMP_DOWN = 2'd1;
    localparam logic [1:0] c_ST_DEAD      = 2'd2;

    logic [7:0]          r_sync1;
    logic [7:0]          r_sync2;
    logic [7:0]          w_deb;
    logic [3:0]          w_dec_duty;
    logic                w_dec_fwd;
    logic [3:0]          r_tgt_duty;
    logic                r_tgt_fwd;
    logic [3:0]          r_duty;
    logic                r_dir_fwd;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_DEAD_W-1:0] r_dead;
    logic                w_dir_match;
    logic [3:0]          w_run_duty;
    logic [3:0]          w_down_duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 8'd0;
            r_sync2 <= 8'd0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_deb
        logic [c_DEB_W-1:0] r_cnt;
        logic               r_bit;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_bit <= 1'b0;
            end else if (r_sync2[gi] == r_bit) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt <= '0;
                r_bit <= r_sync2[gi];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_deb[gi] = r_bit;
    end

    // Highest-numbered switch wins; no switch keeps the present direction.
    always_comb begin
        w_dec_duty = 4'd0;
        w_dec_fwd  = r_dir_fwd;
        if (w_deb[7]) begin
            w_dec_duty = 4'd3;  w_dec_fwd = 1'b0;
        end else if (w_deb[6]) begin
            w_dec_duty = 4'd5;  w_dec_fwd = 1'b0;
        end else if (w_deb[5]) begin
            w_dec_duty = 4'd7;  w_dec_fwd = 1'b0;
        end else if (w_deb[4]) begin
            w_dec_duty = 4'd10; w_dec_fwd = 1'b0;
        end else if (w_deb[3]) begin
            w_dec_duty = 4'd3;  w_dec_fwd = 1'b1;
        end else if (w_deb[2]) begin
            w_dec_duty = 4'd5;  w_dec_fwd = 1'b1;
        end else if (w_deb[1]) begin
            w_dec_duty = 4'd7;  w_dec_fwd = 1'b1;
        end else if (w_deb[0]) begin
            w_dec_duty = 4'd10; w_dec_fwd = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tgt_duty <= 4'd0;
            r_tgt_fwd  <= 1'b1;
        end else begin
            r_tgt_duty <= w_dec_duty;
            r_tgt_fwd  <= w_dec_fwd;
        end
    end

    assign w_dir_match = (r_tgt_fwd == r_dir_fwd);

`ifdef MOTOR_CMD_RAMP_EN
    localparam int c_PRE_W = $clog2(RAMP_CYCLES + 1);

    logic [c_PRE_W-1:0] r_pre;
    logic               w_tick;

    assign w_tick = (r_pre == c_PRE_W'(RAMP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_comb begin
        w_run_duty = r_duty;
        if (w_tick && (r_duty < r_tgt_duty)) begin
            w_run_duty = r_duty + 4'd1;
        end else if (w_tick && (r_duty > r_tgt_duty)) begin
            w_run_duty = r_duty - 4'd1;
        end
    end

    assign w_down_duty = (w_tick && (r_duty != 4'd0)) ? (r_duty - 4'd1) : r_duty;
`else
    // Without slewing the step interval collapses to a single cycle.
    if (RAMP_CYCLES >= 1) begin : g_direct
        assign w_run_duty  = r_tgt_duty;
        assign w_down_duty = 4'd0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (!w_dir_match && (r_tgt_duty != 4'd0)) begin
                    w_state_nxt = c_ST_RAMP_DOWN;
                end
            end
            c_ST_RAMP_DOWN: begin
                if (w_dir_match) begin
                    w_state_nxt = c_ST_RUN;
                end else if (r_duty == 4'd0) begin
                    w_state_nxt = c_ST_DEAD;
                end
            end
            c_ST_DEAD: begin
                if (r_dead == '0) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: w_state_nxt = c_ST_RUN;
        endcase
    end

    always_comb begin
        coast = (r_state == c_ST_DEAD);
        busy  = (r_state != c_ST_RUN);
    end

    // Held preloaded outside DEAD so the full coast time always elapses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dead <= '0;
        end else if (r_state != c_ST_DEAD) begin
            r_dead <= c_DEAD_W'(DEAD_CYCLES - 1);
        end else if (r_dead != '0) begin
            r_dead <= r_dead - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty    <= 4'd0;
            r_dir_fwd <= 1'b1;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_dir_match) begin
                        r_duty <= w_run_duty;
                    end
                end
                c_ST_RAMP_DOWN: r_duty <= w_down_duty;
                c_ST_DEAD: begin
                    r_duty <= 4'd0;
                    if ((r_dead == '0) && (r_tgt_duty != 4'd0)) begin
                        r_dir_fwd <= r_tgt_fwd;
                    end
                end
                default: r_duty <= 4'd0;
            endcase
        end
    end

    assign duty    = r_duty;
    assign dir_fwd = r_dir_fwd;

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_cmd_ramp
// Brief    : Self-checking bench for motor_cmd_ramp (vector table, directed
//            corner sequences, randomized switch settings vs. target model).
// Revision : 1.0  initial release
// ============================================================================
module tb_motor_cmd_ramp;

    localparam int c_DEB  = 4;
    localparam int c_RAMP = 8;
    localparam int c_DEAD = 16;
    localparam int c_STABLE = 2 * c_RAMP + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw  = 8'd0;
    logic [3:0] duty;
    logic       dir_fwd;
    logic       coast;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    motor_cmd_ramp #(
        .DEBOUNCE_CYCLES(c_DEB),
        .RAMP_CYCLES    (c_RAMP),
        .DEAD_CYCLES    (c_DEAD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .duty   (duty),
        .dir_fwd(dir_fwd),
        .coast  (coast),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Target from the switch rules: top asserted switch picks speed and direction.
    function automatic void model(input logic [7:0] s, input bit cur_fwd,
                                  output int d, output bit f);
        int speed [4];
        speed = '{10, 7, 5, 3};
        d = 0;
        f = cur_fwd;
        for (int i = 7; i >= 0; i--) begin
            if (s[i]) begin
                d = speed[i % 4];
                f = (i < 4);
                break;
            end
        end
    endfunction

    // Per-cycle rules that hold whatever the stimulus.
    bit   mon_en = 1'b0;
    bit   mon_init = 1'b0;
    bit   have_phase;
    int   cyc;
    int   phase_cyc;
    logic [3:0] prev_duty;
    logic       prev_dir;
    logic       prev_coast;

    always @(posedge clk) begin
        #2;
        if (!mon_en) begin
            mon_init = 1'b0;
        end else if (!mon_init) begin
            mon_init   = 1'b1;
            have_phase = 1'b0;
            cyc        = 0;
            prev_duty  = duty;
            prev_dir   = dir_fwd;
            prev_coast = coast;
        end else begin
            cyc++;
            check("duty_range", int'(duty <= 4'd10), 1);
            if (coast) check("coast_idle", int'(duty == 4'd0 && busy), 1);
            if (dir_fwd != prev_dir) check("dir_flip_at_coast_end", int'(prev_coast && !coast), 1);
`ifdef MOTOR_CMD_RAMP_EN
            if (duty != prev_duty) begin
                check("step_size", (duty > prev_duty) ? int'(duty - prev_duty) : int'(prev_duty - duty), 1);
                if (have_phase) begin
                    check("step_phase", (cyc - phase_cyc) % c_RAMP, 0);
                end else begin
                    have_phase = 1'b1;
                    phase_cyc  = cyc;
                end
            end
`endif
            prev_duty  = duty;
            prev_dir   = dir_fwd;
            prev_coast = coast;
        end
    end

    task automatic settle(input string name, input int exp_duty, input bit exp_fwd);
        int         stable_cnt;
        logic [3:0] last;
        stable_cnt = 0;
        step(c_DEB + 5);
        last = duty;
        for (int n = 0; n < 800 && stable_cnt < c_STABLE; n++) begin
            step(1);
            if (duty == last && !busy && !coast) stable_cnt++;
            else stable_cnt = 0;
            last = duty;
        end
        check({name, "_settled"}, int'(stable_cnt >= c_STABLE), 1);
        check({name, "_duty"},  duty,    exp_duty);
        check({name, "_dir"},   dir_fwd, exp_fwd);
        check({name, "_coast"}, coast,   0);
        check({name, "_busy"},  busy,    0);
    endtask

    task automatic wait_busy(input string name);
        int n;
        for (n = 0; n < 40 && !busy; n++) step(1);
        check({name, "_busy_rise"}, busy, 1);
    endtask

    task automatic count_coast(input string name, input bit exp_fwd);
        int n;
        int len;
        for (n = 0; n < 300 && !coast; n++) step(1);
        check({name, "_coast_rise"}, coast, 1);
        len = 0;
        while (coast && len < 60) begin
            len++;
            step(1);
        end
        check({name, "_coast_len"}, len, c_DEAD);
        check({name, "_dir_after_dead"}, dir_fwd, exp_fwd);
        check({name, "_busy_after_dead"}, busy, 0);
    endtask

    typedef struct {
        logic [7:0] sw;
        int         duty;
        bit         fwd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        bit         exp_fwd;
        int         exp_duty;
        int         n;
        int         gap;
        bit         coast_seen;
        logic [3:0] last;
        logic [7:0] sw_v;

        vecs[0]  = '{8'h01, 10, 1'b1};
        vecs[1]  = '{8'h02,  7, 1'b1};
        vecs[2]  = '{8'h0F,  3, 1'b1};
        vecs[3]  = '{8'h81,  3, 1'b0};
        vecs[4]  = '{8'h10, 10, 1'b0};
        vecs[5]  = '{8'h00,  0, 1'b0};
        vecs[6]  = '{8'h04,  5, 1'b1};
        vecs[7]  = '{8'h60,  5, 1'b0};
        vecs[8]  = '{8'h20,  7, 1'b0};
        vecs[9]  = '{8'hFF,  3, 1'b0};
        vecs[10] = '{8'h08,  3, 1'b1};
        vecs[11] = '{8'h00,  0, 1'b1};

        // Reset
        rst = 1'b1;
        sw  = 8'h00;
        step(3);
        check("rst_duty", duty, 0);
        check("rst_dir", dir_fwd, 1);
        check("rst_coast", coast, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        step(2);

        // Short pulses must never pass the debouncer.
        coast_seen = 1'b0;
        for (int r = 0; r < 4; r++) begin
            sw = 8'h01;
            for (int k = 0; k < 3; k++) begin step(1); coast_seen |= (duty != 4'd0) || busy; end
            sw = 8'h00;
            for (int k = 0; k < 3; k++) begin step(1); coast_seen |= (duty != 4'd0) || busy; end
        end
        for (int k = 0; k < 12; k++) begin step(1); coast_seen |= (duty != 4'd0) || busy; end
        check("bounce_no_change", coast_seen, 0);

        // Held switch: 2 sync + debounce + 1 decode before anything can move.
        sw = 8'h01;
        step(7);
        check("hold_latency_duty", duty, 0);
`ifdef MOTOR_CMD_RAMP_EN
        for (n = 0; n < 30 && duty == 4'd0; n++) step(1);
        check("ramp_first_step", duty, 1);
        for (int k = 2; k <= 10; k++) begin
            last = duty;
            gap  = 0;
            while (duty == last && gap < 30) begin
                step(1);
                gap++;
            end
            check("ramp_step_gap", gap, c_RAMP);
            check("ramp_step_val", duty, k);
        end
`else
        step(1);
        check("direct_duty", duty, 10);
`endif
        settle("hold_sw0", 10, 1'b1);

        // Forward 10 -> reverse 10
        sw = 8'h10;
        wait_busy("rev");
`ifndef MOTOR_CMD_RAMP_EN
        step(1);
        check("rev_zero_in_one", duty, 0);
`endif
        count_coast("rev", 1'b0);
        settle("rev_final", 10, 1'b0);
        exp_fwd = 1'b0;

`ifdef MOTOR_CMD_RAMP_EN
        // Abort a reversal part way down.
        sw = 8'h02;
        settle("fwd7", 7, 1'b1);
        sw = 8'h10;
        for (n = 0; n < 300 && !(busy && duty == 4'd4); n++) step(1);
        check("abort_reach_4", int'(busy && duty == 4'd4), 1);
        sw = 8'h02;
        coast_seen = 1'b0;
        for (int k = 0; k < 60; k++) begin step(1); coast_seen |= coast; end
        settle("abort_final", 7, 1'b1);
        check("abort_no_coast", coast_seen, 0);
        exp_fwd = 1'b1;
`else
        sw = 8'h04;
        settle("fwd5", 5, 1'b1);
        sw = 8'h02;
        step(7);
        check("direct_lat_before", duty, 5);
        step(1);
        check("direct_lat_after", duty, 7);
        sw = 8'h40;
        wait_busy("rev6");
        step(1);
        check("rev6_zero_in_one", duty, 0);
        count_coast("rev6", 1'b0);
        settle("rev6_final", 5, 1'b0);
        exp_fwd = 1'b0;
`endif

        // Reset in the middle of DEAD.
        sw = exp_fwd ? 8'h80 : 8'h08;
        for (n = 0; n < 300 && !coast; n++) step(1);
        check("dead_reached", coast, 1);
        step(3);
        mon_en = 1'b0;
        rst = 1'b1;
        sw  = 8'h00;
        step(1);
        check("dead_rst_duty", duty, 0);
        check("dead_rst_dir", dir_fwd, 1);
        check("dead_rst_coast", coast, 0);
        check("dead_rst_busy", busy, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        exp_fwd = 1'b1;
        settle("post_rst", 0, 1'b1);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            sw = vecs[i].sw;
            settle($sformatf("vec%0d", i), vecs[i].duty, vecs[i].fwd);
        end
        exp_fwd = 1'b1;

        // Randomized settings against the target model.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0:       sw_v = 8'h00;
                1:       sw_v = 8'(1 << $urandom_range(0, 7));
                default: sw_v = 8'($urandom_range(0, 255));
            endcase
            model(sw_v, exp_fwd, exp_duty, exp_fwd);
            sw = sw_v;
            settle($sformatf("rnd%0d_sw%02h", i, sw_v), exp_duty, exp_fwd);
        end

        mon_en = 1'b0;
        step(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
